// File: rtl/flipflop_write_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N active-low writers, one grant per cycle.
// Optional FLIPFLOP_ARB_LOCK_EN: a granted requester holding Lock and Req keeps the grant for a burst.
module flipflop_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                                  Clk,
  input  logic                                  notClk,
  input  logic                                  Rst,
  input  logic [N-1:0]                          Req,
  input  logic [N*W-1:0]                        notData,
  input  logic [N-1:0]                          Lock,
  output logic [N-1:0]                          Gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  GntId,
  output logic [W-1:0]                          Q,
  output logic [W-1:0]                          notQ,
  output logic                                  Busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_EXT = SW'(N);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]  gnt_r;
  logic [IW-1:0] gntId_r;
  logic [IW-1:0] ptr_r;
  logic          busy_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  notQ_r;

  logic [N-1:0]  elig_s;
  logic [N-1:0]  nextGnt_s;
  logic [IW-1:0] nextGntId_s;
  logic [IW-1:0] nextPtr_s;
  logic          pickFound_s;
  logic [IW-1:0] pickId_s;
  logic          hold_s;
  logic [W-1:0]  wrData_s;
  logic          unusedSink_s;

  // First set bit of elig at or after ptr, wrapping N-1 -> 0; MSB of the result flags a hit.
  function automatic logic [IW:0] rrPick(input logic [N-1:0] elig, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    logic [IW:0] cand;
    res = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + SW'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end else begin
        cand = cand;
      end
      if (!res[IW] && elig[cand[IW-1:0]]) begin
        res = {1'b1, cand[IW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef FLIPFLOP_ARB_LOCK_EN
  assign hold_s       = |(gnt_r & Lock & Req);
  assign unusedSink_s = notClk;
`else
  assign hold_s       = 1'b0;
  assign unusedSink_s = notClk ^ (|Lock);
`endif

  // Next grant: the requester written this edge is masked out of the simultaneous arbitration.
  always_comb begin
    elig_s = Req & ~gnt_r;
    {pickFound_s, pickId_s} = rrPick(elig_s, ptr_r);
    nextGnt_s   = '0;
    nextGntId_s = '0;
    nextPtr_s   = ptr_r;
    if (hold_s) begin
      nextGnt_s   = gnt_r;
      nextGntId_s = gntId_r;
    end else if (pickFound_s) begin
      nextGnt_s   = ONE_HOT0 << pickId_s;
      nextGntId_s = pickId_s;
      if (pickId_s == LAST_ID) begin
        nextPtr_s = '0;
      end else begin
        nextPtr_s = pickId_s + IW'(1);
      end
    end else begin
      nextGnt_s = '0;
    end
  end

  // Active-low data of the currently granted requester (gnt_r is one-hot or zero).
  always_comb begin
    wrData_s = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_r[i]) begin
        wrData_s = wrData_s | notData[i*W +: W];
      end else begin
        wrData_s = wrData_s;
      end
    end
  end

  // Arbitration state: grant, grant index, round-robin pointer, busy flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      gnt_r   <= '0;
      gntId_r <= '0;
      ptr_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      gnt_r   <= nextGnt_s;
      gntId_r <= nextGntId_s;
      ptr_r   <= nextPtr_s;
      busy_r  <= |nextGnt_s;
    end
  end

  // Shared register (NOR-cell flip-flops, modelled behaviourally); loads only under a grant.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_r    <= '0;
      notQ_r <= '1;
    end else if (|gnt_r) begin
      q_r    <= ~wrData_s;
      notQ_r <= wrData_s;
    end else begin
      q_r    <= q_r;
      notQ_r <= notQ_r;
    end
  end

  assign Gnt   = gnt_r;
  assign GntId = gntId_r;
  assign Busy  = busy_r;
  assign Q     = q_r;
  assign notQ  = notQ_r;

endmodule
